// File: rtl/stream_demux.sv
// Time-multiplexed word stream to parallel frame demultiplexer.
// Words collect into per-slot shadow registers, and each complete frame is published on out_data.
module stream_demux #(
    parameter int WIDTH  = 4,
    parameter int NSLOTS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    input  logic                     in_sof,
    output logic                     in_ready,
    output logic [NSLOTS*WIDTH-1:0]  out_data,
    output logic                     frame_valid,
    input  logic                     frame_ack,
    output logic                     sync_err
);

    localparam int IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLOTS - 1);

    typedef enum logic {COLLECT, HOLD} mode_t;

    mode_t                   mode, mode_next;
    logic [IW-1:0]           idx, idx_next;
    logic [WIDTH-1:0]        shadow [NSLOTS];
    logic [NSLOTS*WIDTH-1:0] frame_next;
    logic                    accept, at_last, complete, ack, resync, sync_err_next;

    assign at_last     = (idx == LAST);
    assign frame_valid = (mode == HOLD);
    assign ack         = frame_ack & frame_valid;
    // Only stall the final word of a frame, and only if the held frame is not leaving this cycle.
    assign in_ready    = !(at_last && frame_valid && !frame_ack);
    assign accept      = in_valid & in_ready;
    assign resync      = accept & in_sof & (idx != '0);
    assign complete    = accept & ~in_sof & at_last;

    always_comb begin
        mode_next     = mode;
        idx_next      = idx;
        sync_err_next = sync_err;
        frame_next    = '0;

        case (mode)
            COLLECT: if (complete) mode_next = HOLD;
            HOLD:    if (ack && !complete) mode_next = COLLECT;
            default: mode_next = COLLECT;
        endcase

        if (accept) begin
            if (in_sof)       idx_next = IW'(1);
            else if (at_last) idx_next = '0;
            else              idx_next = idx + 1'b1;
        end

        // A restart in the same cycle as an acknowledge must leave the flag set.
        if (resync)   sync_err_next = 1'b1;
        else if (ack) sync_err_next = 1'b0;

        for (int k = 0; k < NSLOTS - 1; k++) begin
            frame_next[k*WIDTH +: WIDTH] = shadow[k];
        end
        frame_next[(NSLOTS-1)*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= COLLECT;
            idx      <= '0;
            sync_err <= 1'b0;
            out_data <= '0;
            for (int k = 0; k < NSLOTS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            mode     <= mode_next;
            idx      <= idx_next;
            sync_err <= sync_err_next;
            if (complete) out_data <= frame_next;
            if (accept)   shadow[in_sof ? '0 : idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: expected frames are queued at stimulus time
// and compared by a monitor whenever a presented frame is acknowledged.
module tb_stream_demux;

    localparam int WIDTH  = 4;
    localparam int NSLOTS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        frame_ack = 1'b0;
    logic        in_ready;
    logic        frame_valid;
    logic        sync_err;
    logic [15:0] out_data;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] expq [$];

    stream_demux #(.WIDTH(WIDTH), .NSLOTS(NSLOTS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] d, input logic sof);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: word %0h never accepted", d);
        end
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
    endtask

    task automatic ackFrame();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    // Monitor: a frame is consumed on the edge following a negedge where valid and ack are both high.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ack) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_frame: got %0h, expected none", out_data);
            end else begin
                checkOutput("frame", 32'(out_data), 32'(expq.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        checkOutput("reset_fv",    32'(frame_valid), 32'h0);
        checkOutput("reset_out",   32'(out_data),    32'h0);
        checkOutput("reset_err",   32'(sync_err),    32'h0);
        checkOutput("reset_ready", 32'(in_ready),    32'h1);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic frame and one-cycle publish latency
        applyStimulus(4'h1, 1'b1);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h3, 1'b0);
        checkOutput("t1_fv_early", 32'(frame_valid), 32'h0);
        expq.push_back(16'h4321);
        applyStimulus(4'h4, 1'b0);
        checkOutput("t1_fv",  32'(frame_valid), 32'h1);
        checkOutput("t1_out", 32'(out_data),    32'h4321);
        checkOutput("t1_err", 32'(sync_err),    32'h0);

        // Backpressure on the last word while a frame is held
        applyStimulus(4'h5, 1'b1);
        applyStimulus(4'h6, 1'b0);
        applyStimulus(4'h7, 1'b0);
        expq.push_back(16'h8765);
        in_valid = 1'b1;
        in_data  = 4'h8;
        checkOutput("t2_ready_stall", 32'(in_ready), 32'h0);
        tick();
        checkOutput("t2_ready_stall2", 32'(in_ready), 32'h0);
        checkOutput("t2_held",         32'(out_data), 32'h4321);
        frame_ack = 1'b1;
        #1;
        checkOutput("t2_ready_ack", 32'(in_ready), 32'h1);
        tick();
        frame_ack = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        checkOutput("t2_fv",  32'(frame_valid), 32'h1);
        checkOutput("t2_out", 32'(out_data),    32'h8765);

        // Resync mid-frame
        ackFrame();
        checkOutput("t3_fv_clear", 32'(frame_valid), 32'h0);
        applyStimulus(4'h1, 1'b1);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h9, 1'b1);
        checkOutput("t3_err_set", 32'(sync_err), 32'h1);
        applyStimulus(4'hA, 1'b0);
        applyStimulus(4'hB, 1'b0);
        expq.push_back(16'hCBA9);
        applyStimulus(4'hC, 1'b0);
        checkOutput("t3_fv",  32'(frame_valid), 32'h1);
        checkOutput("t3_out", 32'(out_data),    32'hCBA9);
        checkOutput("t3_err", 32'(sync_err),    32'h1);
        ackFrame();
        checkOutput("t3_err_clear", 32'(sync_err),    32'h0);
        checkOutput("t3_fv_clear",  32'(frame_valid), 32'h0);

        // Ack coinciding with completion keeps frame_valid high
        expq.push_back(16'hA5A5);
        applyStimulus(4'h5, 1'b1);
        applyStimulus(4'hA, 1'b0);
        applyStimulus(4'h5, 1'b0);
        applyStimulus(4'hA, 1'b0);
        applyStimulus(4'hD, 1'b1);
        applyStimulus(4'hE, 1'b0);
        applyStimulus(4'hF, 1'b0);
        expq.push_back(16'h0FED);
        in_valid  = 1'b1;
        in_data   = 4'h0;
        frame_ack = 1'b1;
        tick();
        in_valid  = 1'b0;
        frame_ack = 1'b0;
        checkOutput("t4_fv",  32'(frame_valid), 32'h1);
        checkOutput("t4_out", 32'(out_data),    32'h0FED);
        checkOutput("t4_err", 32'(sync_err),    32'h0);
        ackFrame();
        checkOutput("t4_fv_clear", 32'(frame_valid), 32'h0);

        // Asynchronous reset mid-frame
        applyStimulus(4'h1, 1'b1);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h1, 1'b1);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h3, 1'b0);
        checkOutput("t5_err_pre", 32'(sync_err), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_out",   32'(out_data),    32'h0);
        checkOutput("t5_rst_fv",    32'(frame_valid), 32'h0);
        checkOutput("t5_rst_err",   32'(sync_err),    32'h0);
        checkOutput("t5_rst_ready", 32'(in_ready),    32'h1);
        tick();
        rst_n = 1'b1;
        expq.push_back(16'h7654);
        applyStimulus(4'h4, 1'b0);
        applyStimulus(4'h5, 1'b0);
        applyStimulus(4'h6, 1'b0);
        applyStimulus(4'h7, 1'b0);
        checkOutput("t5_fv",  32'(frame_valid), 32'h1);
        checkOutput("t5_out", 32'(out_data),    32'h7654);
        checkOutput("t5_err", 32'(sync_err),    32'h0);

        // Inputs ignored while in_valid is low
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b0;
            in_sof   = 1'b1;
            in_data  = 4'($urandom_range(0, 15));
            tick();
        end
        in_sof  = 1'b0;
        in_data = '0;
        checkOutput("t6_fv",  32'(frame_valid), 32'h1);
        checkOutput("t6_out", 32'(out_data),    32'h7654);
        checkOutput("t6_err", 32'(sync_err),    32'h0);
        ackFrame();
        expq.push_back(16'h0123);
        applyStimulus(4'h3, 1'b0);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h1, 1'b0);
        applyStimulus(4'h0, 1'b0);
        checkOutput("t6_idx_fv",  32'(frame_valid), 32'h1);
        checkOutput("t6_idx_out", 32'(out_data),    32'h0123);
        ackFrame();

        checkOutput("queue_drained", 32'(expq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
